// File: rtl/rtc_irq_pio.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rtc_irq_pio                                                     |
// | Purpose  : Avalon-MM input port for RTC alarm lines: sync, debounce, edge  |
// |            capture (W1C) and maskable level interrupt.                     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module rtc_irq_pio #(
    parameter int WIDTH           = 1,
    parameter int EDGE_TYPE       = 1,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int         C_CNT_W     = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [1:0] C_ADDR_DATA = 2'd0;
    localparam logic [1:0] C_ADDR_RAW  = 2'd1;
    localparam logic [1:0] C_ADDR_MASK = 2'd2;
    localparam logic [1:0] C_ADDR_CAP  = 2'd3;

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_db_d;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] w_db;
    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_rd;
    logic             w_wr;

    assign w_wr = chipselect & ~write_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= in_port;
            r_s2 <= r_s1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES > 0) begin : g_debounce
            localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(DEBOUNCE_CYCLES - 1);
            for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
                logic [C_CNT_W-1:0] r_cnt;
                logic               r_db;
                // A new level is accepted only after N consecutive disagreeing cycles.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_cnt <= '0;
                        r_db  <= 1'b0;
                    end else if (r_s2[gi] == r_db) begin
                        r_cnt <= '0;
                    end else if (r_cnt == C_CNT_MAX) begin
                        r_db  <= r_s2[gi];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                assign w_db[gi] = r_db;
            end
        end else begin : g_no_debounce
            assign w_db = r_s2;
        end
    endgenerate

    generate
        if (EDGE_TYPE == 0) begin : g_edge_rise
            assign w_sel = w_db & ~r_db_d;
        end else if (EDGE_TYPE == 1) begin : g_edge_fall
            assign w_sel = ~w_db & r_db_d;
        end else begin : g_edge_any
            assign w_sel = w_db ^ r_db_d;
        end
    endgenerate

    assign w_clr = (w_wr && (address == C_ADDR_CAP)) ? writedata[WIDTH-1:0] : '0;

    // Set has priority over W1C so an edge landing on a clear is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_db_d <= '0;
            r_mask <= '0;
            r_cap  <= '0;
        end else begin
            r_db_d <= w_db;
            r_cap  <= (r_cap & ~w_clr) | w_sel;
            if (w_wr && (address == C_ADDR_MASK)) begin
                r_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        w_rd = '0;
        case (address)
            C_ADDR_DATA: w_rd = w_db;
            C_ADDR_RAW:  w_rd = r_s2;
            C_ADDR_MASK: w_rd = r_mask;
            C_ADDR_CAP:  w_rd = r_cap;
            default:     w_rd = '0;
        endcase
    end

    assign readdata = 32'(w_rd);
    assign irq      = |(r_cap & r_mask);

    generate
        if (WIDTH < 32) begin : g_unused_wdata
            logic w_unused_wdata;
            assign w_unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rtc_irq_pio.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rtc_irq_pio                                                  |
// | Purpose  : Directed self-checking bench for rtc_irq_pio (three configs).   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_rtc_irq_pio;

    logic clk = 1'b0;
    logic reset;
    always #50 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // a: WIDTH=1 rising N=4; b: WIDTH=4 any N=0; c: defaults (WIDTH=1 falling N=4)
    logic [1:0]  a_addr, b_addr, c_addr;
    logic        a_cs, b_cs, c_cs;
    logic        a_wn, b_wn, c_wn;
    logic [31:0] a_wd, b_wd, c_wd;
    logic [31:0] a_rd, b_rd, c_rd;
    logic [0:0]  a_in, c_in;
    logic [3:0]  b_in;
    logic        a_irq, b_irq, c_irq;

    rtc_irq_pio #(.WIDTH(1), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(4)) dut_a (
        .clk(clk), .reset(reset), .address(a_addr), .chipselect(a_cs), .write_n(a_wn),
        .writedata(a_wd), .readdata(a_rd), .in_port(a_in), .irq(a_irq)
    );
    rtc_irq_pio #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .address(b_addr), .chipselect(b_cs), .write_n(b_wn),
        .writedata(b_wd), .readdata(b_rd), .in_port(b_in), .irq(b_irq)
    );
    rtc_irq_pio dut_c (
        .clk(clk), .reset(reset), .address(c_addr), .chipselect(c_cs), .write_n(c_wn),
        .writedata(c_wd), .readdata(c_rd), .in_port(c_in), .irq(c_irq)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input int u, input logic [1:0] ad, input logic [31:0] exp, input string tag);
        logic [31:0] v;
        case (u)
            0:       a_addr = ad;
            1:       b_addr = ad;
            default: c_addr = ad;
        endcase
        #1;
        case (u)
            0:       v = a_rd;
            1:       v = b_rd;
            default: v = c_rd;
        endcase
        chk(tag, v, exp);
    endtask

    task automatic wr(input int u, input logic [1:0] ad, input logic [31:0] d);
        case (u)
            0:       begin a_cs = 1'b1; a_wn = 1'b0; a_addr = ad; a_wd = d; end
            1:       begin b_cs = 1'b1; b_wn = 1'b0; b_addr = ad; b_wd = d; end
            default: begin c_cs = 1'b1; c_wn = 1'b0; c_addr = ad; c_wd = d; end
        endcase
        tick(1);
        a_cs = 1'b0; a_wn = 1'b1;
        b_cs = 1'b0; b_wn = 1'b1;
        c_cs = 1'b0; c_wn = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        a_addr = 2'd0; a_cs = 1'b0; a_wn = 1'b1; a_wd = '0; a_in = 1'b0;
        b_addr = 2'd0; b_cs = 1'b0; b_wn = 1'b1; b_wd = '0; b_in = 4'h0;
        c_addr = 2'd0; c_cs = 1'b0; c_wn = 1'b1; c_wd = '0; c_in = 1'b1;
        tick(3);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(0, 2'(i), 32'h0, "a reset reg");
            rd(1, 2'(i), 32'h0, "b reset reg");
            rd(2, 2'(i), 32'h0, "c reset reg");
        end
        chk("a reset irq", 32'(a_irq), 32'd0);
        chk("b reset irq", 32'(b_irq), 32'd0);
        chk("c reset irq", 32'(c_irq), 32'd0);

        // Rising capture through the 4-cycle debounce
        wr(0, 2'd2, 32'h1);
        rd(0, 2'd2, 32'h1, "a mask");
        a_in = 1'b1;
        tick(2);
        rd(0, 2'd1, 32'h1, "a raw k+1");
        rd(0, 2'd0, 32'h0, "a data k+1");
        tick(3);
        rd(0, 2'd0, 32'h0, "a data k+4");
        tick(1);
        rd(0, 2'd0, 32'h1, "a data k+5");
        rd(0, 2'd3, 32'h0, "a cap k+5");
        chk("a irq k+5", 32'(a_irq), 32'd0);
        tick(1);
        rd(0, 2'd3, 32'h1, "a cap k+6");
        chk("a irq k+6", 32'(a_irq), 32'd1);
        wr(0, 2'd3, 32'h1);
        rd(0, 2'd3, 32'h0, "a cap w1c");
        chk("a irq w1c", 32'(a_irq), 32'd0);

        // Falling edge must not capture on a rising-only port
        a_in = 1'b0;
        tick(8);
        rd(0, 2'd0, 32'h0, "a data fell");
        rd(0, 2'd3, 32'h0, "a cap no fall");

        // 3-cycle glitch is rejected
        a_in = 1'b1;
        tick(3);
        a_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            rd(0, 2'd0, 32'h0, "a glitch data");
            chk("a glitch irq", 32'(a_irq), 32'd0);
        end
        rd(0, 2'd3, 32'h0, "a glitch cap");

        // 4-cycle pulse is accepted
        a_in = 1'b1;
        tick(4);
        a_in = 1'b0;
        tick(2);
        rd(0, 2'd0, 32'h1, "a pulse data k+5");
        tick(1);
        rd(0, 2'd3, 32'h1, "a pulse cap k+6");
        chk("a pulse irq", 32'(a_irq), 32'd1);
        tick(2);
        rd(0, 2'd0, 32'h1, "a pulse data k+8");
        tick(1);
        rd(0, 2'd0, 32'h0, "a pulse data k+9");

        // W1C on the same edge a new rising edge is captured: set wins
        a_in = 1'b1;
        tick(6);
        rd(0, 2'd0, 32'h1, "a simul data");
        rd(0, 2'd3, 32'h1, "a simul cap before");
        wr(0, 2'd3, 32'h1);
        rd(0, 2'd3, 32'h1, "a simul cap after");
        chk("a simul irq", 32'(a_irq), 32'd1);

        // Reset mid-debounce (cnt=2) with capture and mask set
        a_in = 1'b0;
        tick(4);
        rd(0, 2'd0, 32'h1, "a pre-reset data");
        rd(0, 2'd3, 32'h1, "a pre-reset cap");
        chk("a pre-reset irq", 32'(a_irq), 32'd1);
        reset = 1'b1;
        a_in = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            rd(0, 2'(i), 32'h0, "a midreset reg");
        end
        chk("a midreset irq", 32'(a_irq), 32'd0);
        reset = 1'b0;
        tick(6);
        rd(0, 2'd0, 32'h1, "a boot data r6");
        rd(0, 2'd3, 32'h0, "a boot cap r6");
        tick(1);
        rd(0, 2'd3, 32'h1, "a boot cap r7");
        chk("a boot irq masked", 32'(a_irq), 32'd0);

        // Mask gating on the 4-bit any-edge, no-debounce port
        b_in = 4'b0100;
        tick(2);
        rd(1, 2'd0, 32'h4, "b data k+1");
        rd(1, 2'd3, 32'h0, "b cap k+1");
        tick(1);
        rd(1, 2'd3, 32'h4, "b cap k+2");
        chk("b irq unmasked", 32'(b_irq), 32'd0);
        b_in = 4'b0000;
        tick(3);
        rd(1, 2'd0, 32'h0, "b data low");
        rd(1, 2'd3, 32'h4, "b cap hold");
        wr(1, 2'd2, 32'h4);
        rd(1, 2'd2, 32'h4, "b mask");
        chk("b irq masked in", 32'(b_irq), 32'd1);
        wr(1, 2'd3, 32'h0);
        rd(1, 2'd3, 32'h4, "b cap w0");
        chk("b irq w0", 32'(b_irq), 32'd1);
        wr(1, 2'd3, 32'h4);
        rd(1, 2'd3, 32'h0, "b cap w1c");
        chk("b irq w1c", 32'(b_irq), 32'd0);
        b_in = 4'b1011;
        tick(2);
        rd(1, 2'd1, 32'hB, "b raw multi");
        rd(1, 2'd0, 32'hB, "b data multi");
        tick(1);
        rd(1, 2'd3, 32'hB, "b cap multi");
        chk("b irq multi", 32'(b_irq), 32'd0);
        wr(1, 2'd2, 32'hFFFF_FFFF);
        rd(1, 2'd2, 32'hF, "b mask width");
        chk("b irq all", 32'(b_irq), 32'd1);
        wr(1, 2'd0, 32'h0);
        rd(1, 2'd0, 32'hB, "b data ro");

        // Default config: falling-edge capture, high-at-boot not flagged
        rd(2, 2'd0, 32'h1, "c data high");
        rd(2, 2'd3, 32'h0, "c cap no rise");
        c_in = 1'b0;
        tick(6);
        rd(2, 2'd0, 32'h0, "c data k+5");
        rd(2, 2'd3, 32'h0, "c cap k+5");
        tick(1);
        rd(2, 2'd3, 32'h1, "c cap k+6");
        chk("c irq masked", 32'(c_irq), 32'd0);
        wr(2, 2'd2, 32'h1);
        chk("c irq enabled", 32'(c_irq), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
